// File: rtl/corr_window_ctrl_pkg.sv
// corr_window_ctrl_pkg.sv -- shared state type, widths and byte helper for the
// correlator window controller slice (package sdr_ctrl_pkg).
package sdr_ctrl_pkg;

  localparam int SUM_W     = 24;
  localparam int BYTE_W    = 8;
  localparam int NUM_BYTES = 3;
  localparam int IDX_W     = $clog2(NUM_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    ACCUM   = 3'd2,
    MACWAIT = 3'd3,
    SEND    = 3'd4
  } ctrlState_e;

  // Pick byte number idx (0 = least significant) out of a full MAC sum.
  function automatic logic [BYTE_W-1:0] selectByte(input logic [SUM_W-1:0] word,
                                                  input logic [IDX_W-1:0] idx);
    logic [SUM_W-1:0] shifted;
    shifted = word >> (int'(idx) * BYTE_W);
    return shifted[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/corr_window_ctrl_if.sv
// corr_window_ctrl_if.sv -- control, datapath and result-stream signals of the
// correlator window controller. The controller sits on the slave modport; the
// datapath/host side uses the master modport.
interface corr_window_ctrl_if;
  import sdr_ctrl_pkg::*;

  logic              start;
  logic              sample_valid;
  logic [SUM_W-1:0]  sum_in;
  logic              res_ready;
  logic              acc_clr;
  logic              acc_en;
  logic              mac_start;
  logic [BYTE_W-1:0] res_data;
  logic              res_valid;
  logic              busy;
  logic              overrun;
  logic              timeout;

  modport master (
    output start, sample_valid, sum_in, res_ready,
    input  acc_clr, acc_en, mac_start, res_data, res_valid, busy, overrun, timeout
  );

  modport slave (
    input  start, sample_valid, sum_in, res_ready,
    output acc_clr, acc_en, mac_start, res_data, res_valid, busy, overrun, timeout
  );

endinterface

// File: rtl/corr_window_ctrl_sum_serializer.sv
// corr_window_ctrl_sum_serializer.sv -- module sum_serializer: holds the captured
// 24-bit MAC sum and streams it out LSB byte first over a valid/ready handshake.
module sum_serializer
  import sdr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [SUM_W-1:0]  sum_i,
  input  logic              ready_i,
  output logic [BYTE_W-1:0] data_o,
  output logic              valid_o,
  output logic              done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] byteIdx_q, byteIdx_d;
  logic             valid_q, valid_d;
  logic             xfer;
  logic             lastXfer;

  // Load a new sum, or step to the next byte on each accepted transfer.
  always_comb begin
    sum_d     = sum_q;
    byteIdx_d = byteIdx_q;
    valid_d   = valid_q;
    xfer      = valid_q && ready_i;
    lastXfer  = xfer && (byteIdx_q == LAST_IDX);
    if (load_i) begin
      sum_d     = sum_i;
      byteIdx_d = '0;
      valid_d   = 1'b1;
    end else if (xfer) begin
      if (lastXfer) begin
        byteIdx_d = '0;
        valid_d   = 1'b0;
      end else begin
        byteIdx_d = byteIdx_q + 1'b1;
      end
    end
  end

  // Sum register, byte index and valid flag; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      byteIdx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      byteIdx_q <= byteIdx_d;
      valid_q   <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = valid_q ? selectByte(sum_q, byteIdx_q) : '0;
  assign done_o  = lastXfer;

endmodule

// File: rtl/corr_window_ctrl.sv
// corr_window_ctrl.sv -- window controller for the correlator histogram/MAC
// datapath: clears the bins, counts WIN_LEN valid samples, launches the MAC,
// captures its sum and hands it to sum_serializer.
// Optional feature: define CTRL_TIMEOUT_EN to add an ACCUM idle watchdog.
module corr_window_ctrl
  import sdr_ctrl_pkg::*;
#(
  parameter int WIN_LEN = 256,
  parameter int MAC_LAT = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  corr_window_ctrl_if.slave  bus
);

  if (WIN_LEN < 1 || WIN_LEN > 65535) begin : g_badWinLen
    $error("corr_window_ctrl: WIN_LEN must be 1..65535");
  end
  if (MAC_LAT < 1 || MAC_LAT > 15) begin : g_badMacLat
    $error("corr_window_ctrl: MAC_LAT must be 1..15");
  end
  if (TIMEOUT < 1) begin : g_badTimeout
    $error("corr_window_ctrl: TIMEOUT must be at least 1");
  end

  localparam logic [15:0] LAST_SAMPLE = 16'(WIN_LEN - 1);
  localparam logic [3:0]  CAPTURE_AT  = 4'(MAC_LAT);

  ctrlState_e  state_q, state_d;
  logic [15:0] sampleCnt_q, sampleCnt_d;
  logic [3:0]  latCnt_q, latCnt_d;
  logic        overrun_q, overrun_d;
  logic        serLoad;
  logic        serDone;

`ifdef CTRL_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdCnt_q, wdCnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Next-state logic, counters, sticky flags and the per-state strobes.
  always_comb begin
    state_d       = state_q;
    sampleCnt_d   = sampleCnt_q;
    latCnt_d      = 4'd0;
    overrun_d     = overrun_q;
    serLoad       = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.acc_en    = 1'b0;
    bus.mac_start = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    wdCnt_d       = '0;
    timeout_d     = timeout_q;
`endif

    if (bus.start && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    if (bus.sample_valid && (state_q != ACCUM)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CLEAR;
          overrun_d = 1'b0;
`ifdef CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      CLEAR: begin
        bus.acc_clr = 1'b1;
        sampleCnt_d = 16'd0;
        state_d     = ACCUM;
      end
      ACCUM: begin
        bus.acc_en = bus.sample_valid;
`ifdef CTRL_TIMEOUT_EN
        wdCnt_d = wdCnt_q + 1'b1;
`endif
        if (bus.sample_valid) begin
          sampleCnt_d = sampleCnt_q + 16'd1;
`ifdef CTRL_TIMEOUT_EN
          wdCnt_d = '0;
`endif
          if (sampleCnt_q == LAST_SAMPLE) begin
            state_d = MACWAIT;
          end
        end
`ifdef CTRL_TIMEOUT_EN
        else if (wdCnt_q == WD_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      MACWAIT: begin
        bus.mac_start = (latCnt_q == 4'd0);
        latCnt_d      = latCnt_q + 4'd1;
        if (latCnt_q == CAPTURE_AT) begin
          serLoad  = 1'b1;
          latCnt_d = 4'd0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (serDone) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sampleCnt_q <= 16'd0;
      latCnt_q    <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      latCnt_q    <= latCnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdCnt_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdCnt_q   <= wdCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.busy    = (state_q != IDLE);
  assign bus.overrun = overrun_q;

  sum_serializer u_serializer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (serLoad),
    .sum_i   (bus.sum_in),
    .ready_i (bus.res_ready),
    .data_o  (bus.res_data),
    .valid_o (bus.res_valid),
    .done_o  (serDone)
  );

endmodule

// File: doc/corr_window_ctrl.md
CORR_WINDOW_CTRL -- requirements
Module: corr_window_ctrl

Interface
REQ-001 WIN_LEN, default 256: valid samples accumulated per window; range 1..65535.
REQ-002 MAC_LAT, default 2: cycles from mac_start to a valid sum_in; range 1..15.
REQ-003 TIMEOUT, default 1024: idle-cycle limit in ACCUM; used only with CTRL_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to begin one window.
REQ-007 sample_valid  in  1  new I/Q sample present at the histogram inputs.
REQ-008 sum_in  in  24  total MAC sum from the datapath.
REQ-009 res_ready  in  1  downstream accepts res_data.
REQ-010 acc_clr  out  1  one-cycle clear of all histogram bins.
REQ-011 acc_en  out  1  histogram count enable for the current sample.
REQ-012 mac_start  out  1  one-cycle MAC launch.
REQ-013 res_data  out  8  serialized result byte.
REQ-014 res_valid  out  1  res_data is valid.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 overrun  out  1  sticky; start was ignored or a sample was dropped.
REQ-017 timeout  out  1  sticky; the window was aborted by the watchdog.

Function
REQ-018 FSM states: IDLE, CLEAR, ACCUM, MACWAIT, SEND.
REQ-019 IDLE: start moves to CLEAR and clears overrun and timeout in the same edge.
REQ-020 CLEAR: lasts 1 cycle, asserts acc_clr, zeroes the sample counter, then moves to ACCUM.
REQ-021 ACCUM: acc_en = sample_valid, combinational; the counter increments on each valid sample.
REQ-022 ACCUM exit: the WIN_LEN-th valid sample is counted, then the next state is MACWAIT.
REQ-023 MACWAIT: mac_start pulses on the first cycle only.
REQ-024 MACWAIT capture: after MAC_LAT further cycles, sum_in is latched into a 24-bit register and the FSM moves to SEND.
REQ-025 SEND: emits 3 bytes LSB first (sum[7:0], sum[15:8], sum[23:16]) with res_valid high.
REQ-026 SEND handshake: a byte transfers when res_valid and res_ready are both high; res_data is held stable while res_ready is low.
REQ-027 SEND exit: after the third transfer, the FSM returns to IDLE and res_valid drops on the next cycle.
REQ-028 Window latency, zero backpressure: mac_start is asserted 1 cycle after the last sample; the first res_valid is asserted MAC_LAT+1 cycles after mac_start.
REQ-029 start outside IDLE is ignored and sets overrun.
REQ-030 sample_valid outside ACCUM is dropped, gives acc_en=0, and sets overrun.
REQ-031 In IDLE, a start and sample_valid in the same cycle are both handled: the transition is taken, and overrun is set then cleared, so it ends at 0.
REQ-032 WIN_LEN=1: the first valid sample in ACCUM ends the window.

Reset
REQ-033 rst overrides every other input, including mid-window and mid-SEND.
REQ-034 Reset values: state=IDLE, counter=0, sum register=0, and all outputs 0 (res_data=8'h00).
REQ-035 No partial result is emitted after a reset.

Configuration
REQ-036 Macro CTRL_TIMEOUT_EN, when defined, adds an ACCUM watchdog.
REQ-037 The watchdog counts cycles with no sample_valid and reloads on each valid sample.
REQ-038 When the watchdog reaches TIMEOUT: timeout is set, the FSM goes to IDLE, and no mac_start or output is produced.
REQ-039 Without CTRL_TIMEOUT_EN: ACCUM waits indefinitely, timeout is tied 0, and no watchdog logic is present.

Structure
REQ-040 Package sdr_ctrl_pkg holds the state enum, SUM_W=24, BYTE_W=8, and NUM_BYTES=3.
REQ-041 Sub-module sum_serializer handles the 24-to-8 conversion: load, byte index, and the valid/ready handshake.
REQ-042 The FSM and counters remain in corr_window_ctrl.

Verification
REQ-043 Nominal window: WIN_LEN=4, MAC_LAT=2, start, 4 consecutive samples, sum_in=24'hABCDEF, res_ready=1.
- Required: acc_clr pulse, then 4 acc_en, then mac_start 1 cycle later.
- Required: bytes EF, CD, AB on consecutive cycles, then IDLE.
REQ-044 Backpressure: res_ready low for 3 cycles on byte 1; byte 1 (CD) is held stable, and 3 transfers total occur.
REQ-045 Misuse: start during ACCUM and a sample during CLEAR; overrun=1, the window count is unaffected, and the next accepted start clears overrun.
REQ-046 Mid-window reset: rst in ACCUM after 2 samples, then start with 4 samples; acc_clr is issued again and exactly one 3-byte result is produced.
REQ-047 Watchdog: with CTRL_TIMEOUT_EN and TIMEOUT=8, stall samples in ACCUM; after 8 cycles timeout=1, the FSM is in IDLE, and mac_start never asserts. Without the macro the FSM remains in ACCUM.
